// File: rtl/camera_frame_gen.sv
// OV7670-style camera emulator: drives vsync/href/data on pclk with RGB565 test patterns,
// two bytes per pixel, high byte first.
module camera_frame_gen #(
    parameter int H_ACTIVE   = 160,
    parameter int V_ACTIVE   = 120,
    parameter int VSYNC_CYC  = 3,
    parameter int VBACK_CYC  = 2,
    parameter int HBLANK_CYC = 4,
    parameter int VFRONT_CYC = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] color_in,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done
);

    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_W = H_ACTIVE / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_LINE,
        S_HBLANK,
        S_VFRONT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            phase_q, phase_d;
    logic [XW-1:0]   bar_cnt_q, bar_cnt_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic [15:0]     pix_cnt_q, pix_cnt_d;
    logic [1:0]      pat_q, pat_d;
    logic [15:0]     color_q, color_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;
    logic            frame_done_q, frame_done_d;

    logic            enter_vsync;
    logic [15:0]     bar_rgb;
    logic [15:0]     pixel;

    always_comb begin
        bar_rgb = 16'h0000;
        case (bar_idx_q)
            3'd0: bar_rgb = 16'hFFFF;
            3'd1: bar_rgb = 16'hFFE0;
            3'd2: bar_rgb = 16'h07FF;
            3'd3: bar_rgb = 16'h07E0;
            3'd4: bar_rgb = 16'hF81F;
            3'd5: bar_rgb = 16'hF800;
            3'd6: bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    // Checkerboard is evaluated on zero-extended coordinates so narrow x/y still work.
    always_comb begin
        pixel = color_q;
        case (pat_q)
            2'd0: pixel = color_q;
            2'd1: pixel = bar_rgb;
            2'd2: pixel = pix_cnt_q;
            default: pixel = (((32'(x_q) ^ 32'(y_q)) & 32'd8) != 32'd0) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        bar_cnt_d    = bar_cnt_q;
        bar_idx_d    = bar_idx_q;
        pix_cnt_d    = pix_cnt_q;
        pat_d        = pat_q;
        color_d      = color_q;
        vsync_d      = 1'b0;
        href_d       = 1'b0;
        data_d       = 8'h00;
        frame_done_d = 1'b0;
        enter_vsync  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d     = S_VSYNC;
                    enter_vsync = 1'b1;
                end
            end
            S_VSYNC: begin
                vsync_d = 1'b1;
                if (timer_q == 8'(VSYNC_CYC - 1)) begin
                    timer_d = 8'd0;
                    state_d = S_VBACK;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_VBACK: begin
                if (timer_q == 8'(VBACK_CYC - 1)) begin
                    timer_d = 8'd0;
                    state_d = S_LINE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_LINE: begin
                href_d  = 1'b1;
                data_d  = phase_q ? pixel[7:0] : pixel[15:8];
                phase_d = ~phase_q;
                if (phase_q) begin
                    pix_cnt_d = pix_cnt_q + 16'd1;
                    if (x_q == XW'(H_ACTIVE - 1)) begin
                        x_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = 3'd0;
                        if (y_q == YW'(V_ACTIVE - 1)) begin
                            state_d = S_VFRONT;
                        end else begin
                            y_d     = y_q + 1'b1;
                            state_d = S_HBLANK;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == XW'(BAR_W - 1)) begin
                            bar_cnt_d = '0;
                            bar_idx_d = bar_idx_q + 3'd1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (timer_q == 8'(HBLANK_CYC - 1)) begin
                    timer_d = 8'd0;
                    state_d = S_LINE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_VFRONT: begin
                frame_done_d = (timer_q == 8'd0);
                if (timer_q == 8'(VFRONT_CYC - 1)) begin
                    timer_d = 8'd0;
                    if (enable) begin
                        state_d     = S_VSYNC;
                        enter_vsync = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase

        // Frame settings are frozen here so mid-frame input changes cannot tear a frame.
        if (enter_vsync) begin
            pat_d     = pattern_sel;
            color_d   = color_in;
            x_d       = '0;
            y_d       = '0;
            phase_d   = 1'b0;
            bar_cnt_d = '0;
            bar_idx_d = 3'd0;
            pix_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= 8'd0;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= 3'd0;
            pix_cnt_q    <= 16'd0;
            pat_q        <= 2'd0;
            color_q      <= 16'd0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            pat_q        <= pat_d;
            color_q      <= color_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;

endmodule
